writeback_unit: RTL and testbench

Writeback stage driving the register file's single write port (`reg_num_w`, `w_data`, `ctrl_reg_w`). It merges single-cycle ALU results with multi-cycle load responses. ALU results have priority. Loads use a valid/ready handshake. A starvation counter forces a pipeline stall so a blocked load can retire. Sub-word load data is extracted and extended here, and writes to x0 are suppressed.

---
 rtl/writeback_unit_if.sv | 46 ++++
 rtl/writeback_unit.sv | 134 +++++++++++++
 tb/tb_writeback_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_unit_if.sv
// Register-file writeback bus: ALU result, load response handshake, stall and write port.
// Scoreboard issue/pending signals exist only when WB_SCOREBOARD_EN is defined.
interface writeback_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic [2:0]        ld_funct3;
  logic [1:0]        ld_byte_off;
  logic              stall_req;
  logic [ADDR_W-1:0] reg_num_w;
  logic [DATA_W-1:0] w_data;
  logic              ctrl_reg_w;
`ifdef WB_SCOREBOARD_EN
  logic                 ld_issue_valid;
  logic [ADDR_W-1:0]    ld_issue_rd;
  logic [2**ADDR_W-1:0] pending_mask;
`endif

  // master: pipeline / memory side that produces results; slave: the writeback unit
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data, ld_funct3, ld_byte_off,
`ifdef WB_SCOREBOARD_EN
    output ld_issue_valid, ld_issue_rd,
    input  pending_mask,
`endif
    input  ld_ready, stall_req, reg_num_w, w_data, ctrl_reg_w
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data, ld_funct3, ld_byte_off,
`ifdef WB_SCOREBOARD_EN
    input  ld_issue_valid, ld_issue_rd,
    output pending_mask,
`endif
    output ld_ready, stall_req, reg_num_w, w_data, ctrl_reg_w
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage merging ALU results (priority) and load responses onto one register-file write port; optional WB_SCOREBOARD_EN tracks pending loads.
// Latency 1 cycle; loads back-pressured via ld_ready, and a starved load forces stall_req to freeze the ALU side.
module writeback_unit #(
  parameter int RISC_V_DATA_WIDTH           = 32,
  parameter int REGISTER_FILE_ADDRESS_WIDTH = 5,
  parameter int STARVE_LIMIT                = 4
) (
  input logic             clk,
  input logic             rst,
  writeback_unit_if.slave bus
);
  localparam int DATA_W = RISC_V_DATA_WIDTH;
  localparam int ADDR_W = REGISTER_FILE_ADDRESS_WIDTH;
  localparam int CNT_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_cnt_nxt;
  logic              stall_req;
  logic              ld_ready;
  logic              ld_accept;
  logic              alu_grant;
  logic              ld_starved;

  logic [ADDR_W-1:0] reg_num_w_q;
  logic [DATA_W-1:0] w_data_q;
  logic              ctrl_reg_w_q;

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;

  // stall_req depends only on the counter register, never on this cycle's inputs
  assign stall_req  = (starve_cnt == LIMIT);
  assign ld_ready   = stall_req | ~bus.alu_valid;
  assign ld_accept  = bus.ld_valid & ld_ready;
  assign alu_grant  = bus.alu_valid & ~stall_req;
  assign ld_starved = bus.ld_valid & ~ld_ready;

  always_comb begin
    starve_cnt_nxt = '0;
    if (ld_starved) begin
      starve_cnt_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
    end
  end

  always_comb begin
    ld_byte = bus.ld_data[7:0];
    case (bus.ld_byte_off)
      2'd0: ld_byte = bus.ld_data[7:0];
      2'd1: ld_byte = bus.ld_data[15:8];
      2'd2: ld_byte = bus.ld_data[23:16];
      2'd3: ld_byte = bus.ld_data[31:24];
      default: ld_byte = bus.ld_data[7:0];
    endcase
  end

  assign ld_half = bus.ld_byte_off[1] ? bus.ld_data[31:16] : bus.ld_data[15:0];

  // Unknown funct3 encodings fall back to a full-word load
  always_comb begin
    ld_ext = bus.ld_data;
    case (bus.ld_funct3)
      3'b000:  ld_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_ext = bus.ld_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_num_w_q  <= '0;
      w_data_q     <= '0;
      ctrl_reg_w_q <= 1'b0;
    end else begin
      ctrl_reg_w_q <= 1'b0;
      if (alu_grant) begin
        reg_num_w_q  <= bus.alu_rd;
        w_data_q     <= bus.alu_data;
        ctrl_reg_w_q <= (bus.alu_rd != '0);
      end else if (ld_accept) begin
        reg_num_w_q  <= bus.ld_rd;
        w_data_q     <= ld_ext;
        ctrl_reg_w_q <= (bus.ld_rd != '0);
      end
    end
  end

  assign bus.ld_ready   = ld_ready;
  assign bus.stall_req  = stall_req;
  assign bus.reg_num_w  = reg_num_w_q;
  assign bus.w_data     = w_data_q;
  assign bus.ctrl_reg_w = ctrl_reg_w_q;

`ifdef WB_SCOREBOARD_EN
  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (bus.ld_issue_valid && (bus.ld_issue_rd != '0)) begin
      set_vec[bus.ld_issue_rd] = 1'b1;
    end
    if (ld_accept) begin
      clr_vec[bus.ld_rd] = 1'b1;
    end
  end

  // A new issue to the register retiring this edge must stay pending
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= ((pending_q & ~clr_vec) | set_vec) & ~NREG'(1);
    end
  end

  assign bus.pending_mask = pending_q;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit (build with WB_SCOREBOARD_EN to cover the scoreboard).
module tb_writeback_unit;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  writeback_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  writeback_unit #(
    .RISC_V_DATA_WIDTH(DW),
    .REGISTER_FILE_ADDRESS_WIDTH(AW),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_rd       = '0;
    bus.ld_data     = '0;
    bus.ld_funct3   = 3'b010;
    bus.ld_byte_off = 2'd0;
`ifdef WB_SCOREBOARD_EN
    bus.ld_issue_valid = 1'b0;
    bus.ld_issue_rd    = '0;
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.ctrl_reg_w !== 1'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=0", bus.ctrl_reg_w); end
    checks++; if (bus.reg_num_w !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", bus.reg_num_w); end
    checks++; if (bus.w_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.w_data); end
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall_req); end
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got=%b exp=1", bus.ld_ready); end
  endtask

  task automatic test_alu();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'h0000_1234;
    #1;
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL alu_ld_ready got=%b exp=0", bus.ld_ready); end
    tick();
    bus.alu_valid = 1'b0;
    checks++; if (bus.ctrl_reg_w !== 1'b1) begin errors++; $display("FAIL alu_ctrl got=%b exp=1", bus.ctrl_reg_w); end
    checks++; if (bus.reg_num_w !== 5'd5) begin errors++; $display("FAIL alu_rd got=%0d exp=5", bus.reg_num_w); end
    checks++; if (bus.w_data !== 32'h0000_1234) begin errors++; $display("FAIL alu_data got=%h exp=00001234", bus.w_data); end
    tick();
    checks++; if (bus.ctrl_reg_w !== 1'b0) begin errors++; $display("FAIL alu_idle_ctrl got=%b exp=0", bus.ctrl_reg_w); end
    checks++; if (bus.reg_num_w !== 5'd5) begin errors++; $display("FAIL alu_idle_hold_rd got=%0d exp=5", bus.reg_num_w); end
    checks++; if (bus.w_data !== 32'h0000_1234) begin errors++; $display("FAIL alu_idle_hold_data got=%h exp=00001234", bus.w_data); end
  endtask

  task automatic test_load_extract();
    logic [2:0]  f3  [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011, 3'b000, 3'b001};
    logic [1:0]  off [8] = '{2'd3,   2'd1,   2'd2,   2'd0,   2'd0,   2'd2,   2'd0,   2'd0};
    logic [31:0] exp [8] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01,
                             32'h80FF_7F01, 32'h80FF_7F01, 32'h0000_0001, 32'h0000_7F01};
    for (int i = 0; i < 8; i++) begin
      bus.ld_valid    = 1'b1;
      bus.ld_rd       = 5'(10 + i);
      bus.ld_data     = 32'h80FF_7F01;
      bus.ld_funct3   = f3[i];
      bus.ld_byte_off = off[i];
      #1;
      checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL load%0d_ready got=%b exp=1", i, bus.ld_ready); end
      tick();
      checks++; if (bus.ctrl_reg_w !== 1'b1) begin errors++; $display("FAIL load%0d_ctrl got=%b exp=1", i, bus.ctrl_reg_w); end
      checks++; if (bus.reg_num_w !== 5'(10 + i)) begin errors++; $display("FAIL load%0d_rd got=%0d exp=%0d", i, bus.reg_num_w, 10 + i); end
      checks++; if (bus.w_data !== exp[i]) begin errors++; $display("FAIL load%0d_data got=%h exp=%h", i, bus.w_data, exp[i]); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_starvation();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_data  = 32'h0000_AAAA;
    bus.ld_valid  = 1'b1;
    bus.ld_rd     = 5'd4;
    bus.ld_data   = 32'h1122_3344;
    bus.ld_funct3 = 3'b010;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL starve_c%0d_ready got=%b exp=0", c, bus.ld_ready); end
      checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL starve_c%0d_stall got=%b exp=0", c, bus.stall_req); end
      tick();
      checks++; if (bus.reg_num_w !== 5'd3) begin errors++; $display("FAIL starve_c%0d_alu_rd got=%0d exp=3", c, bus.reg_num_w); end
    end
    checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL starve_stall got=%b exp=1", bus.stall_req); end
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL starve_ready got=%b exp=1", bus.ld_ready); end
    tick();
    bus.ld_valid = 1'b0;
    checks++; if (bus.reg_num_w !== 5'd4) begin errors++; $display("FAIL starve_load_rd got=%0d exp=4", bus.reg_num_w); end
    checks++; if (bus.w_data !== 32'h1122_3344) begin errors++; $display("FAIL starve_load_data got=%h exp=11223344", bus.w_data); end
    checks++; if (bus.ctrl_reg_w !== 1'b1) begin errors++; $display("FAIL starve_load_ctrl got=%b exp=1", bus.ctrl_reg_w); end
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL starve_release got=%b exp=0", bus.stall_req); end
    tick();
    bus.alu_valid = 1'b0;
    checks++; if (bus.reg_num_w !== 5'd3) begin errors++; $display("FAIL starve_alu_after_rd got=%0d exp=3", bus.reg_num_w); end
    checks++; if (bus.w_data !== 32'h0000_AAAA) begin errors++; $display("FAIL starve_alu_after_data got=%h exp=0000aaaa", bus.w_data); end
    tick();
    idle_inputs();
  endtask

  task automatic test_x0();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'h0000_DEAD;
    tick();
    bus.alu_valid = 1'b0;
    checks++; if (bus.ctrl_reg_w !== 1'b0) begin errors++; $display("FAIL x0_alu_ctrl got=%b exp=0", bus.ctrl_reg_w); end
    checks++; if (bus.reg_num_w !== 5'd0) begin errors++; $display("FAIL x0_alu_rd got=%0d exp=0", bus.reg_num_w); end
    checks++; if (bus.w_data !== 32'h0000_DEAD) begin errors++; $display("FAIL x0_alu_data got=%h exp=0000dead", bus.w_data); end
    bus.ld_valid  = 1'b1;
    bus.ld_rd     = 5'd0;
    bus.ld_data   = 32'h5555_5555;
    bus.ld_funct3 = 3'b010;
    #1;
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL x0_ld_ready got=%b exp=1", bus.ld_ready); end
    tick();
    bus.ld_valid = 1'b0;
    checks++; if (bus.ctrl_reg_w !== 1'b0) begin errors++; $display("FAIL x0_ld_ctrl got=%b exp=0", bus.ctrl_reg_w); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'(i + 20);
      bus.alu_data  = 32'(i * 32'h0101_0101);
      tick();
      checks++; if (bus.ctrl_reg_w !== 1'b1) begin errors++; $display("FAIL b2b%0d_ctrl got=%b exp=1", i, bus.ctrl_reg_w); end
      checks++; if (bus.reg_num_w !== 5'(i + 20)) begin errors++; $display("FAIL b2b%0d_rd got=%0d exp=%0d", i, bus.reg_num_w, i + 20); end
      checks++; if (bus.w_data !== 32'(i * 32'h0101_0101)) begin errors++; $display("FAIL b2b%0d_data got=%h exp=%h", i, bus.w_data, 32'(i * 32'h0101_0101)); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd9;
    bus.alu_data  = 32'h0BAD_F00D;
    bus.ld_valid  = 1'b1;
    bus.ld_rd     = 5'd8;
    bus.ld_funct3 = 3'b010;
    tick();
    tick();
    tick();
    checks++; if (bus.ctrl_reg_w !== 1'b1) begin errors++; $display("FAIL rstmid_pre_ctrl got=%b exp=1", bus.ctrl_reg_w); end
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL rstmid_pre_stall got=%b exp=0", bus.stall_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++; if (bus.ctrl_reg_w !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got=%b exp=0", bus.ctrl_reg_w); end
    checks++; if (bus.reg_num_w !== 5'd0) begin errors++; $display("FAIL rstmid_rd got=%0d exp=0", bus.reg_num_w); end
    checks++; if (bus.w_data !== 32'h0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", bus.w_data); end
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL rstmid_stall got=%b exp=0", bus.stall_req); end
    // Counter must restart from zero: one more blocked cycle must not stall
    bus.alu_valid = 1'b1;
    bus.ld_valid  = 1'b1;
    tick();
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL rstmid_cnt_restart got=%b exp=0", bus.stall_req); end
    idle_inputs();
    tick();
  endtask

`ifdef WB_SCOREBOARD_EN
  task automatic test_scoreboard();
    bus.ld_issue_valid = 1'b1;
    bus.ld_issue_rd    = 5'd7;
    tick();
    checks++; if (bus.pending_mask !== 32'h0000_0080) begin errors++; $display("FAIL sb_set got=%h exp=00000080", bus.pending_mask); end
    bus.ld_valid  = 1'b1;
    bus.ld_rd     = 5'd7;
    bus.ld_funct3 = 3'b010;
    tick();
    checks++; if (bus.pending_mask !== 32'h0000_0080) begin errors++; $display("FAIL sb_set_wins got=%h exp=00000080", bus.pending_mask); end
    bus.ld_issue_valid = 1'b0;
    tick();
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL sb_clear got=%h exp=0", bus.pending_mask); end
    bus.ld_valid       = 1'b0;
    bus.ld_issue_valid = 1'b1;
    bus.ld_issue_rd    = 5'd0;
    tick();
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL sb_x0 got=%h exp=0", bus.pending_mask); end
    idle_inputs();
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu();
    test_load_extract();
    test_starvation();
    test_x0();
    test_back_to_back();
    test_reset_mid();
`ifdef WB_SCOREBOARD_EN
    test_scoreboard();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
